// File: rtl/dado_pkg.sv
// Shared types and constants for the electronic-die sequencer.
package dado_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        OCIOSO,
        ROLANDO,
        DESACELERANDO,
        EXIBINDO
    } estado_t;

    // Code that makes the 7-segment decoder blank the display
    localparam logic [3:0] CONTAGEM_APAGADO = 4'hF;

    // Next die face: wraps from the largest value back to zero
    function automatic logic [3:0] proxima_face(input logic [3:0] atual,
                                                input logic [3:0] maximo);
        if (atual == maximo) begin
            return 4'd0;
        end
        return atual + 4'd1;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Button conditioning: 2-FF synchronizer, debouncer and edge pulses.
module debounce_botao #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    output logic press,
    output logic solta,
    output logic nivel
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sinc_a;
    logic          sinc_b;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc_a <= 1'b0;
            sinc_b <= 1'b0;
        end else begin
            sinc_a <= botao;
            sinc_b <= sinc_a;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            nivel <= 1'b0;
            press <= 1'b0;
            solta <= 1'b0;
        end else begin
            press <= 1'b0;
            solta <= 1'b0;
            if (sinc_b != nivel) begin
                if (cnt == CNT_FIM) begin
                    cnt   <= '0;
                    nivel <= sinc_b;
                    press <= sinc_b;
                    solta <= ~sinc_b;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/controle_dado.sv
// Electronic-die sequencer: fast roll while the button is held, geometric
// deceleration after release, then holds the result for the decoder.
module controle_dado
    import dado_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DIV_RAPIDO      = 1250000,
    parameter int unsigned PASSOS_LENTOS   = 6,
    parameter int unsigned VALOR_MAX       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       botao,
    input  logic       limpar,
    output logic [3:0] contagem,
    output logic       rolando,
    output logic       pronto
);

    localparam int unsigned W  = $clog2(DIV_RAPIDO << PASSOS_LENTOS) + 1;
    localparam int unsigned KW = $clog2(PASSOS_LENTOS + 1);

    localparam logic [W-1:0]  BASE      = W'(DIV_RAPIDO);
    localparam logic [KW-1:0] K_ULTIMO  = KW'(PASSOS_LENTOS - 1);
    localparam logic [3:0]    FACE_MAX  = 4'(VALOR_MAX);

    logic press;
    logic solta;
    logic nivel;
    logic press_ok;

    estado_t       estado;
    estado_t       estado_nxt;
    logic [3:0]    cont_nxt;
    logic [KW-1:0] k;
    logic [KW-1:0] k_nxt;
    logic [W-1:0]  div;
    logic [W-1:0]  div_nxt;
    logic [W-1:0]  intervalo;
    logic          tick;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .botao (botao),
        .press (press),
        .solta (solta),
        .nivel (nivel)
    );

    // press and nivel are registered on the same edge, so this qualification never drops a real press
    assign press_ok = press & nivel;

    // Current prescaler interval: fast while rolling, doubling per decel step
    always_comb begin
        intervalo = BASE;
        if (estado == DESACELERANDO) begin
            intervalo = BASE << (k + KW'(1));
        end
    end

    assign tick = (div == (intervalo - W'(1)));

    // Next-state logic; limpar overrides everything, and any state change
    // swallows a coincident tick and restarts the prescaler
    always_comb begin
        estado_nxt = estado;
        cont_nxt   = contagem;
        k_nxt      = k;
        div_nxt    = tick ? '0 : (div + W'(1));

        case (estado)
            OCIOSO: begin
                cont_nxt = CONTAGEM_APAGADO;
                div_nxt  = '0;
                if (press_ok) begin
                    estado_nxt = ROLANDO;
                    cont_nxt   = 4'd0;
                end
            end
            ROLANDO: begin
                if (solta) begin
                    estado_nxt = DESACELERANDO;
                    k_nxt      = '0;
                end else if (tick) begin
                    cont_nxt = proxima_face(contagem, FACE_MAX);
                end
            end
            DESACELERANDO: begin
                if (press_ok) begin
                    estado_nxt = ROLANDO;
                    k_nxt      = '0;
                end else if (tick) begin
                    cont_nxt = proxima_face(contagem, FACE_MAX);
                    if (k == K_ULTIMO) begin
                        estado_nxt = EXIBINDO;
                    end else begin
                        k_nxt = k + KW'(1);
                    end
                end
            end
            EXIBINDO: begin
                div_nxt = '0;
                if (press_ok) begin
                    estado_nxt = ROLANDO;
                end
            end
        endcase

        if (limpar) begin
            estado_nxt = OCIOSO;
            cont_nxt   = CONTAGEM_APAGADO;
            k_nxt      = '0;
        end

        if (estado_nxt != estado) begin
            div_nxt = '0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= OCIOSO;
            contagem <= CONTAGEM_APAGADO;
            k        <= '0;
            div      <= '0;
            rolando  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            estado   <= estado_nxt;
            contagem <= cont_nxt;
            k        <= k_nxt;
            div      <= div_nxt;
            rolando  <= (estado_nxt == ROLANDO) || (estado_nxt == DESACELERANDO);
            pronto   <= (estado_nxt == EXIBINDO);
        end
    end

endmodule

// File: tb/tb_controle_dado.sv
// Directed bench for controle_dado with a cycle-tagged expectation queue.
module tb_controle_dado;

    logic       clk;
    logic       rst;
    logic       botao;
    logic       limpar;
    logic [3:0] contagem;
    logic       rolando;
    logic       pronto;

    typedef struct {
        int unsigned ciclo;
        logic [5:0]  valor;
        string       tag;
    } esperado_t;

    esperado_t   fila[$];
    int unsigned ciclo = 0;
    int          comparados = 0;
    int          erros = 0;

    controle_dado #(
        .DEBOUNCE_CYCLES(4),
        .DIV_RAPIDO     (3),
        .PASSOS_LENTOS  (2),
        .VALOR_MAX      (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .botao    (botao),
        .limpar   (limpar),
        .contagem (contagem),
        .rolando  (rolando),
        .pronto   (pronto)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: value after the n-th rising edge is n
    always @(posedge clk) ciclo <= ciclo + 1;

    // Pop and compare every expectation due for the edge just past
    always @(negedge clk) begin
        esperado_t  e;
        logic [5:0] obs;
        while (fila.size() > 0 && fila[0].ciclo <= ciclo) begin
            e   = fila.pop_front();
            obs = {contagem, rolando, pronto};
            comparados++;
            assert (e.ciclo == ciclo && obs === e.valor) else begin
                erros++;
                $error("FAIL %s @ciclo %0d (due %0d): obtido cont=%h rol=%b pro=%b esperado cont=%h rol=%b pro=%b",
                       e.tag, ciclo, e.ciclo, obs[5:2], obs[1], obs[0],
                       e.valor[5:2], e.valor[1], e.valor[0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic avanca(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ir_para(input int unsigned alvo);
        while (ciclo < alvo) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic espera(input int unsigned c, input logic [3:0] cont,
                          input logic rol, input logic pro, input string tag);
        esperado_t e;
        e.ciclo = c;
        e.valor = {cont, rol, pro};
        e.tag   = tag;
        fila.push_back(e);
    endtask

    task automatic faixa(input int unsigned de, input int unsigned ate, input logic [3:0] cont,
                         input logic rol, input logic pro, input string tag);
        for (int unsigned c = de; c <= ate; c++) begin
            espera(c, cont, rol, pro, tag);
        end
    endtask

    initial begin
        int unsigned c0, b, l, e, d, x, z, r0;

        rst    = 1'b1;
        botao  = 1'b0;
        limpar = 1'b0;

        // 1. reset and idle
        avanca(2);
        espera(ciclo, 4'hF, 1'b0, 1'b0, "em_reset");
        avanca(1);
        rst = 1'b0;
        c0  = ciclo;
        faixa(c0, c0 + 19, 4'hF, 1'b0, 1'b0, "ocioso");
        ir_para(c0 + 20);

        // 2. bouncing button, then held high
        b = ciclo;
        l = b + 20;
        faixa(b, l + 6, 4'hF, 1'b0, 1'b0, "quicando");
        for (int i = 0; i < 10; i++) begin
            botao = (i % 2 == 0);
            avanca(2);
        end
        botao = 1'b1;

        // 3. rolling: steps every 3 cycles, wraps 5 -> 0
        e = l + 7;
        for (int unsigned k = 0; k <= 25; k++) begin
            espera(e + k, 4'((k / 3) % 6), 1'b1, 1'b0, "rolando");
        end

        // 4. release at value 2: increments after 6 and then 12 more cycles
        d = e + 26;
        faixa(d, d + 5, 4'd2, 1'b1, 1'b0, "desacel_k0");
        faixa(d + 6, d + 17, 4'd3, 1'b1, 1'b0, "desacel_k1");
        faixa(d + 18, d + 117, 4'd4, 1'b0, 1'b1, "exibindo");

        // 5. press in EXIBINDO continues from 4; press during decel
        x = d + 118;
        for (int unsigned k = 0; k <= 8; k++) begin
            espera(x + k, 4'((4 + k / 3) % 6), 1'b1, 1'b0, "reroll");
        end
        faixa(x + 9, x + 14, 4'd0, 1'b1, 1'b0, "desacel_tick_suprimido");
        espera(x + 15, 4'd1, 1'b1, 1'b0, "desacel_passo");
        faixa(x + 16, x + 18, 4'd1, 1'b1, 1'b0, "press_desacel");
        faixa(x + 19, x + 21, 4'd2, 1'b1, 1'b0, "rolando_de_novo");
        faixa(x + 22, x + 24, 4'd3, 1'b1, 1'b0, "rolando_de_novo");
        faixa(x + 25, x + 31, 4'd4, 1'b1, 1'b0, "k_reiniciado");
        faixa(x + 32, x + 43, 4'd5, 1'b1, 1'b0, "k_reiniciado");
        faixa(x + 44, x + 49, 4'd0, 1'b0, 1'b1, "exibindo_2");

        // 6. limpar coincident with press, later solta ignored
        z = x + 50;
        faixa(z, z + 6, 4'd0, 1'b0, 1'b1, "exibindo_2");
        faixa(z + 7, z + 31, 4'hF, 1'b0, 1'b0, "limpar_com_press");
        faixa(z + 32, z + 33, 4'd0, 1'b1, 1'b0, "rolando_3");
        faixa(z + 34, z + 56, 4'hF, 1'b0, 1'b0, "limpar_rolando");
        faixa(z + 57, z + 59, 4'd0, 1'b1, 1'b0, "rolando_4");
        espera(z + 60, 4'd1, 1'b1, 1'b0, "rolando_4");

        ir_para(e + 19);
        botao = 1'b0;
        ir_para(d + 111);
        botao = 1'b1;
        ir_para(x + 2);
        botao = 1'b0;
        ir_para(x + 9);
        botao = 1'b1;
        ir_para(x + 19);
        botao = 1'b0;
        ir_para(z);
        botao = 1'b1;
        ir_para(z + 6);
        limpar = 1'b1;
        ir_para(z + 7);
        limpar = 1'b0;
        ir_para(z + 10);
        botao = 1'b0;
        ir_para(z + 25);
        botao = 1'b1;
        ir_para(z + 33);
        limpar = 1'b1;
        ir_para(z + 34);
        limpar = 1'b0;
        ir_para(z + 36);
        botao = 1'b0;
        ir_para(z + 50);
        botao = 1'b1;

        // reset mid-roll takes effect without waiting for a clock edge
        ir_para(z + 61);
        rst   = 1'b1;
        botao = 1'b0;
        #1;
        comparados++;
        assert ({contagem, rolando, pronto} === {4'hF, 1'b0, 1'b0}) else begin
            erros++;
            $error("FAIL reset_assincrono: obtido cont=%h rol=%b pro=%b esperado cont=f rol=0 pro=0",
                   contagem, rolando, pronto);
        end
        avanca(2);
        rst = 1'b0;
        r0  = ciclo;
        faixa(r0, r0 + 11, 4'hF, 1'b0, 1'b0, "pos_reset");

        for (int i = 0; i < 200 && fila.size() > 0; i++) begin
            avanca(1);
        end
        comparados++;
        assert (fila.size() == 0) else begin
            erros++;
            $error("FAIL fila_pendente: obtido %0d entries left esperado 0", fila.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, erros);
        $finish;
    end

endmodule
